// File: rtl/sifive_reset_sequencer_if.sv
// Purpose: bundles the request/lock/software-reset inputs and the sequenced
//          reset outputs of sifive_reset_sequencer.
// Signals:
//   areq      async reset request, active-high
//   locked    async per-channel lock/ready
//   sw_reset  sync 1-cycle per-channel software re-reset pulse
//   reset_out active-high per-channel resets, bit 0 released first
//   done      all channels released
//   state     0=HOLD 1=RELEASE 2=RUN
// Modports: master drives requests and observes resets; slave is the sequencer.
interface sifive_reset_sequencer_if #(
    parameter int unsigned CHANNELS = 4
);
    logic                areq;
    logic [CHANNELS-1:0] locked;
    logic [CHANNELS-1:0] sw_reset;
    logic [CHANNELS-1:0] reset_out;
    logic                done;
    logic [1:0]          state;

    modport master (
        output areq,
        output locked,
        output sw_reset,
        input  reset_out,
        input  done,
        input  state
    );

    modport slave (
        input  areq,
        input  locked,
        input  sw_reset,
        output reset_out,
        output done,
        output state
    );
endinterface

// File: rtl/sifive_reset_sequencer.sv
// Purpose: releases CHANNELS active-high resets one at a time in index order
//          after a debounced request drop, gated by each channel's lock and a
//          fixed inter-release gap. Lock loss or a software reset on a released
//          channel re-asserts it and every higher channel, then re-sequences.
// Ports:
//   clock    sequencer clock
//   reset_n  synchronous active-low hard reset
//   bus      sifive_reset_sequencer_if.slave (areq, locked, sw_reset in;
//            reset_out, done, state out, all registered)
module sifive_reset_sequencer #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 4,
    parameter int unsigned DEBOUNCE_BITS = 8,
    parameter int unsigned GAP_BITS      = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    sifive_reset_sequencer_if.slave  bus
);

    localparam int unsigned KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [DEBOUNCE_BITS-1:0] DEB_MAX = '1;
    localparam logic [GAP_BITS-1:0]      GAP_MAX = '1;
    localparam logic [KW-1:0]            K_LAST  = KW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0]               areq_sync_q;
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] lock_sync_q;
    logic                                 areq_s;
    logic [CHANNELS-1:0]                  locked_s;

    state_e                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [DEBOUNCE_BITS-1:0]   deb_q, deb_d;
    logic [GAP_BITS-1:0]        gap_q, gap_d;
    logic [CHANNELS-1:0]        rst_out_q, rst_out_d;
    logic                       done_q, done_d;

    logic [CHANNELS-1:0]        released_c;
    logic [CHANNELS-1:0]        roll_cand_c;
    logic                       roll_hit_c;
    logic [KW-1:0]              roll_j_c;

    // Plain shift-chain synchronisers; reset to "request asserted, not locked".
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            areq_sync_q <= '1;
            lock_sync_q <= '0;
        end else begin
            areq_sync_q <= {areq_sync_q[SYNC_STAGES-2:0], bus.areq};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.locked};
        end
    end

    assign areq_s   = areq_sync_q[SYNC_STAGES-1];
    assign locked_s = lock_sync_q[SYNC_STAGES-1];

    // Lowest released channel that lost lock or got a software reset.
    always_comb begin
        released_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            released_c[i] = (state_q == ST_RUN) ||
                            ((state_q == ST_RELEASE) && (KW'(i) < k_q));
        end
        roll_cand_c = (bus.sw_reset | ~locked_s) & released_c;
        roll_hit_c  = |roll_cand_c;
        roll_j_c    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (roll_cand_c[i]) begin
                roll_j_c = KW'(i);
            end
        end
    end

    // Next-state: request override first, then rollback, then in-order release.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        deb_d     = deb_q;
        gap_d     = gap_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;

        if (areq_s) begin
            state_d   = ST_HOLD;
            k_d       = '0;
            deb_d     = DEB_MAX;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rst_out_d = '1;
                    if (deb_q != '0) begin
                        deb_d = deb_q - DEBOUNCE_BITS'(1);
                    end else begin
                        state_d = ST_RELEASE;
                        k_d     = '0;
                        gap_d   = GAP_MAX;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (roll_hit_c) begin
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (KW'(i) >= roll_j_c) begin
                                rst_out_d[i] = 1'b1;
                            end
                        end
                        k_d     = roll_j_c;
                        gap_d   = GAP_MAX;
                        done_d  = 1'b0;
                        state_d = ST_RELEASE;
                    end else if (state_q == ST_RELEASE) begin
                        if (!locked_s[k_q]) begin
                            gap_d = GAP_MAX;
                        end else if (gap_q != '0) begin
                            gap_d = gap_q - GAP_BITS'(1);
                        end else begin
                            rst_out_d[k_q] = 1'b0;
                            gap_d          = GAP_MAX;
                            if (k_q == K_LAST) begin
                                state_d = ST_RUN;
                                done_d  = 1'b1;
                            end else begin
                                k_d = k_q + KW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d   = ST_HOLD;
                    k_d       = '0;
                    deb_d     = DEB_MAX;
                    rst_out_d = '1;
                    done_d    = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_HOLD;
            k_q       <= '0;
            deb_q     <= DEB_MAX;
            gap_q     <= GAP_MAX;
            rst_out_q <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            deb_q     <= deb_d;
            gap_q     <= gap_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    assign bus.reset_out = rst_out_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// Purpose: self-checking bench for sifive_reset_sequencer with default
//          parameters. A behavioural model tracks "how many channels are
//          released" plus debounce/gap counts and input delay lines; directed
//          scenarios add fixed-edge expectations on top.
module tb_sifive_reset_sequencer;

    localparam int CH      = 4;
    localparam int SS      = 4;
    localparam int DB      = 8;
    localparam int GB      = 4;
    localparam int DEB_MAX = (1 << DB) - 1;
    localparam int GAP_MAX = (1 << GB) - 1;
    localparam int FULL    = (1 << CH) - 1;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    sifive_reset_sequencer_if #(.CHANNELS(CH)) bus ();

    sifive_reset_sequencer #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (SS),
        .DEBOUNCE_BITS(DB),
        .GAP_BITS     (GB)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int nvec    = 0;
    int nerr    = 0;
    int edge_no = 0;

    // Reference model: m_n = number of released channels (low bits).
    bit              m_hold;
    int              m_n;
    int              m_deb;
    int              m_gap;
    bit              m_done;
    logic            ah [SS];
    logic [CH-1:0]   lh [SS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    function automatic int exp_rst();
        return (FULL << m_n) & FULL;
    endfunction

    function automatic int exp_state();
        if (m_hold) return 0;
        return (m_n == CH) ? 2 : 1;
    endfunction

    task automatic model_edge(input logic rn, input logic a,
                              input logic [CH-1:0] lk, input logic [CH-1:0] sw);
        logic          as;
        logic [CH-1:0] ls;
        int            cand;
        int            j;
        if (!rn) begin
            m_hold = 1; m_n = 0; m_deb = DEB_MAX; m_gap = GAP_MAX; m_done = 0;
            for (int i = 0; i < SS; i++) begin
                ah[i] = 1'b1;
                lh[i] = '0;
            end
            return;
        end
        as   = ah[SS-1];
        ls   = lh[SS-1];
        cand = int'(sw | ~ls) & ((1 << m_n) - 1);
        if (as) begin
            m_hold = 1; m_n = 0; m_deb = DEB_MAX; m_done = 0;
        end else if (m_hold) begin
            if (m_deb > 0) m_deb--;
            else begin
                m_hold = 0; m_n = 0; m_gap = GAP_MAX;
            end
        end else if (cand != 0) begin
            j = 0;
            for (int i = CH - 1; i >= 0; i--) if (cand[i]) j = i;
            m_n = j; m_gap = GAP_MAX; m_done = 0;
        end else if (m_n < CH) begin
            if (!ls[m_n]) m_gap = GAP_MAX;
            else if (m_gap > 0) m_gap--;
            else begin
                m_n++;
                m_gap = GAP_MAX;
                if (m_n == CH) m_done = 1;
            end
        end
        for (int i = SS - 1; i > 0; i--) begin
            ah[i] = ah[i-1];
            lh[i] = lh[i-1];
        end
        ah[0] = a;
        lh[0] = lk;
    endtask

    // One clock: drive inputs, advance model, compare all outputs.
    task automatic step(input logic rn, input logic a,
                        input logic [CH-1:0] lk, input logic [CH-1:0] sw);
        reset_n      = rn;
        bus.areq     = a;
        bus.locked   = lk;
        bus.sw_reset = sw;
        @(posedge clock);
        #1;
        edge_no = rn ? edge_no + 1 : 0;
        model_edge(rn, a, lk, sw);
        check("reset_out", 32'(bus.reset_out), 32'(exp_rst()));
        check("done", 32'(bus.done), 32'(m_done));
        check("state", 32'(bus.state), 32'(exp_state()));
        bus.sw_reset = '0;
    endtask

    // Full release from reset with fixed expected edge numbers.
    task automatic seq_from_reset(input string tag);
        for (int e = 1; e <= 330; e++) begin
            step(1'b1, 1'b0, 4'hF, 4'h0);
            case (edge_no)
                275: check({tag, "_e275"}, 32'(bus.reset_out), 32'hF);
                276: check({tag, "_e276"}, 32'(bus.reset_out), 32'hE);
                292: check({tag, "_e292"}, 32'(bus.reset_out), 32'hC);
                308: check({tag, "_e308"}, 32'(bus.reset_out), 32'h8);
                323: check({tag, "_e323_done"}, 32'(bus.done), 32'h0);
                324: begin
                    check({tag, "_e324_rst"}, 32'(bus.reset_out), 32'h0);
                    check({tag, "_e324_done"}, 32'(bus.done), 32'h1);
                    check({tag, "_e324_state"}, 32'(bus.state), 32'h2);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [CH-1:0] lk;
        logic [CH-1:0] sw;
        logic          a;
        logic          rn;
        int            bit_i;

        // Reset state and nominal sequence.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'hF, 4'h0);
        check("reset_state_rst", 32'(bus.reset_out), 32'hF);
        check("reset_state_st", 32'(bus.state), 32'h0);
        seq_from_reset("t1");

        // areq glitch at edge 100 during HOLD delays release by 100 edges.
        step(1'b0, 1'b0, 4'hF, 4'h0);
        for (int e = 1; e <= 420; e++) begin
            step(1'b1, (edge_no + 1 == 100), 4'hF, 4'h0);
            if (edge_no == 375) check("t2_e375", 32'(bus.reset_out[0]), 32'h1);
            if (edge_no == 376) check("t2_e376", 32'(bus.reset_out[0]), 32'h0);
        end
        for (int e = 0; e < 40 && exp_state() != 2; e++) step(1'b1, 1'b0, 4'hF, 4'h0);
        check("t2_reach_run", 32'(bus.state), 32'h2);

        // Lock loss on channel 2 in RUN.
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0, (i < 20) ? 4'hB : 4'hF, 4'h0);
            if (i == 3) check("t3_still_run", 32'(bus.state), 32'h2);
            if (i == 4) begin
                check("t3_roll_rst", 32'(bus.reset_out), 32'hC);
                check("t3_roll_done", 32'(bus.done), 32'h0);
                check("t3_roll_st", 32'(bus.state), 32'h1);
            end
            if (i == 38) check("t3_ch2_wait", 32'(bus.reset_out), 32'hC);
            if (i == 39) check("t3_ch2_rel", 32'(bus.reset_out), 32'h8);
            if (i == 55) check("t3_ch3_rel", 32'(bus.reset_out), 32'h0);
        end

        // Software reset of channels 1 and 2 in RUN.
        step(1'b1, 1'b0, 4'hF, 4'b0110);
        check("t4_rst", 32'(bus.reset_out), 32'hE);
        check("t4_st", 32'(bus.state), 32'h1);
        for (int j = 1; j <= 50; j++) begin
            step(1'b1, 1'b0, 4'hF, 4'h0);
            if (j == 15) check("t4_j15", 32'(bus.reset_out), 32'hE);
            if (j == 16) check("t4_j16", 32'(bus.reset_out), 32'hC);
            if (j == 32) check("t4_j32", 32'(bus.reset_out), 32'h8);
            if (j == 48) check("t4_j48", 32'(bus.done), 32'h1);
        end

        // areq reaching the sequencer in the same cycle as sw_reset[0].
        step(1'b1, 1'b1, 4'hF, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'hF, 4'h0);
        step(1'b1, 1'b0, 4'hF, 4'b0001);
        check("t5_state", 32'(bus.state), 32'h0);
        check("t5_rst", 32'(bus.reset_out), 32'hF);
        for (int i = 0; i < 330; i++) step(1'b1, 1'b0, 4'hF, 4'h0);
        check("t5_back_run", 32'(bus.state), 32'h2);

        // Hard reset in the middle of RELEASE with k=2.
        step(1'b1, 1'b0, 4'hF, 4'b0100);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'hF, 4'h0);
        check("t6_k2_rst", 32'(bus.reset_out), 32'hC);
        step(1'b0, 1'b0, 4'hF, 4'h0);
        check("t6_reset_rst", 32'(bus.reset_out), 32'hF);
        check("t6_reset_st", 32'(bus.state), 32'h0);
        seq_from_reset("t6");

        // Random traffic against the model.
        lk = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                bit_i = int'($urandom_range(0, CH - 1));
                lk[bit_i] = ~lk[bit_i];
            end
            a  = ($urandom_range(0, 299) == 0);
            sw = ($urandom_range(0, 59) == 0) ? CH'($urandom) : '0;
            rn = ($urandom_range(0, 1999) != 0);
            step(rn, a, lk, sw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
